// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter of NumChannels ready/valid I2C requesters onto one I2C master port.
// Define I2C_ARB_TIMEOUT_EN to add a master response timeout that completes with o_rsp_error=1.
module i2c_req_arbiter #(
  parameter int NumChannels   = 4,
  parameter int MaxBurst      = 4,
  parameter int TimeoutCycles = 1048576,
  localparam int BW = (MaxBurst > 1) ? $clog2(MaxBurst) : 1,
  localparam int GW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NumChannels-1:0]          i_req_valid,
  output logic [NumChannels-1:0]          o_req_ready,
  input  logic [7*NumChannels-1:0]        i_req_slave_address,
  input  logic [8*NumChannels-1:0]        i_req_reg_address,
  input  logic [BW*NumChannels-1:0]       i_req_burst_count,
  input  logic [8*MaxBurst*NumChannels-1:0] i_req_wdata,
  input  logic [NumChannels-1:0]          i_req_rd_wrn,
  output logic [NumChannels-1:0]          o_rsp_valid,
  input  logic [NumChannels-1:0]          i_rsp_ready,
  output logic [8*MaxBurst-1:0]           o_rsp_rdata,
  output logic                            o_rsp_error,
  output logic                            o_m_valid,
  input  logic                            i_m_ready,
  output logic [6:0]                      o_m_slave_address,
  output logic [7:0]                      o_m_reg_address,
  output logic [BW-1:0]                   o_m_burst_count,
  output logic [8*MaxBurst-1:0]           o_m_wdata,
  output logic                            o_m_rd_wrn,
  input  logic                            i_m_rsp_valid,
  output logic                            o_m_rsp_ready,
  input  logic [8*MaxBurst-1:0]           i_m_rsp_rdata,
  output logic                            o_busy,
  output logic [GW-1:0]                   o_grant_id
);

  if (NumChannels < 1 || NumChannels > 16 || MaxBurst < 1 || MaxBurst > 8 || TimeoutCycles < 1)
  begin : g_bad_params
    $error("i2c_req_arbiter: parameter out of range");
  end

  // Every port pair transfers on a clock edge where valid and ready are both high; once raised,
  // valid and its payload stay stable until that edge.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;

  state_t              state, state_next;
  logic [GW-1:0]       ptr;
  logic                grant_found;
  logic [GW-1:0]       grant_idx;
  logic [31:0]         cand;
  logic                timeout_hit;
  logic [6:0]          sel_slave;
  logic [7:0]          sel_reg;
  logic [BW-1:0]       sel_burst;
  logic [8*MaxBurst-1:0] sel_wdata;
  logic                sel_rd_wrn;

  // First valid channel searching upward from ptr+1, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NumChannels; k++) begin
      cand = (32'(ptr) + 32'(k)) % 32'(NumChannels);
      if (!grant_found && i_req_valid[cand[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    sel_slave  = '0;
    sel_reg    = '0;
    sel_burst  = '0;
    sel_wdata  = '0;
    sel_rd_wrn = 1'b0;
    for (int c = 0; c < NumChannels; c++) begin
      if (GW'(c) == grant_idx) begin
        sel_slave  = i_req_slave_address[7*c +: 7];
        sel_reg    = i_req_reg_address[8*c +: 8];
        sel_burst  = i_req_burst_count[BW*c +: BW];
        sel_wdata  = i_req_wdata[8*MaxBurst*c +: 8*MaxBurst];
        sel_rd_wrn = i_req_rd_wrn[c];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    o_req_ready   = '0;
    o_rsp_valid   = '0;
    o_m_rsp_ready = 1'b0;
    case (state)
      IDLE: begin
        o_m_rsp_ready = 1'b1;
        if (grant_found) begin
          o_req_ready[grant_idx] = 1'b1;
          state_next             = ISSUE;
        end
      end
      ISSUE: if (i_m_ready) state_next = WAIT_RSP;
      WAIT_RSP: begin
        o_m_rsp_ready = 1'b1;
        if (i_m_rsp_valid || timeout_hit) state_next = RESPOND;
      end
      RESPOND: begin
        o_rsp_valid[o_grant_id] = 1'b1;
        if (i_rsp_ready[o_grant_id]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Combinational handshakes are forced low while reset is held.
    if (i_rst) begin
      o_req_ready   = '0;
      o_rsp_valid   = '0;
      o_m_rsp_ready = 1'b0;
      state_next    = IDLE;
    end
  end

  assign o_m_valid = (state == ISSUE);
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr               <= GW'(NumChannels - 1);
      o_grant_id        <= '0;
      o_m_slave_address <= '0;
      o_m_reg_address   <= '0;
      o_m_burst_count   <= '0;
      o_m_wdata         <= '0;
      o_m_rd_wrn        <= 1'b0;
      o_rsp_rdata       <= '0;
    end else begin
      case (state)
        IDLE: if (grant_found) begin
          o_grant_id        <= grant_idx;
          o_m_slave_address <= sel_slave;
          o_m_reg_address   <= sel_reg;
          o_m_burst_count   <= sel_burst;
          o_m_wdata         <= sel_wdata;
          o_m_rd_wrn        <= sel_rd_wrn;
        end
        WAIT_RSP: begin
          if (i_m_rsp_valid)    o_rsp_rdata <= o_m_rd_wrn ? i_m_rsp_rdata : '0;
          else if (timeout_hit) o_rsp_rdata <= '0;
        end
        RESPOND: if (i_rsp_ready[o_grant_id]) ptr <= o_grant_id;
        default: ;
      endcase
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] timer;
  logic        rsp_error_q;

  // A master response in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT_RSP) && (timer == 32'(TimeoutCycles - 1));
  assign o_rsp_error = rsp_error_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer       <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      if (state == ISSUE)         timer <= '0;
      else if (state == WAIT_RSP) timer <= timer + 32'd1;
      if (state == WAIT_RSP) begin
        if (i_m_rsp_valid)    rsp_error_q <= 1'b0;
        else if (timeout_hit) rsp_error_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_rsp_error = 1'b0;
`endif

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Parametrised successor to the single-channel I2C request/response path.
- Arbitrates N independent ready/valid I2C request channels onto one downstream I2C master request/response port.
- Routes each completion, read data or write acknowledge, back to the issuing channel. Bursts are configurable and an optional response timeout guards against a hung master.
- Sits between register-map/UART-access logic (or other requesters) and the I2C master.

Parameters:
NumChannels, 4, number of requester channels (1..16)
MaxBurst, 4, max data bytes per transaction (1..8); BW = max(1,$clog2(MaxBurst))
TimeoutCycles, 1048576, master response timeout in i_clk cycles (with I2C_ARB_TIMEOUT_EN only)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  NumChannels  per-channel request valid
o_req_ready  out  NumChannels  per-channel request accept (one-hot, single cycle)
i_req_slave_address  in  7*NumChannels  packed, channel c at [7c+:7]
i_req_reg_address  in  8*NumChannels  packed register address
i_req_burst_count  in  BW*NumChannels  bytes minus 1
i_req_wdata  in  8*MaxBurst*NumChannels  packed write bytes, byte 0 LSB
i_req_rd_wrn  in  NumChannels  1=read, 0=write
o_rsp_valid  out  NumChannels  per-channel completion valid (one-hot)
i_rsp_ready  in  NumChannels  per-channel completion accept
o_rsp_rdata  out  8*MaxBurst  read data, shared bus
o_rsp_error  out  1  completion was a timeout
o_m_valid  out  1  master request valid
i_m_ready  in  1  master request accept
o_m_slave_address  out  7
o_m_reg_address  out  8
o_m_burst_count  out  BW
o_m_wdata  out  8*MaxBurst
o_m_rd_wrn  out  1
i_m_rsp_valid  in  1  master completion valid
o_m_rsp_ready  out  1  master completion accept
i_m_rsp_rdata  in  8*MaxBurst
o_busy  out  1  FSM not IDLE
o_grant_id  out  $clog2(NumChannels) or 1  currently/last granted channel

Behaviour:
- Reset: all outputs 0, FSM=IDLE, RR pointer=NumChannels-1 so channel 0 wins first. Reset in any state aborts the transaction; no completion is produced.
- FSM states IDLE, ISSUE, WAIT_RSP, RESPOND.
- IDLE:
  - Grant g = first channel with valid, searching pointer+1 upward with wrap mod NumChannels.
  - Assert o_req_ready[g] combinationally the same cycle.
  - Latch that channel's fields and g, then go to ISSUE.
  - No valid: stay in IDLE.
- IDLE drain: o_m_rsp_ready=1 in IDLE; stale master responses are discarded.
- ISSUE: o_m_valid=1 from the cycle after grant. Fields are held stable until i_m_ready=1, then go to WAIT_RSP.
- WAIT_RSP:
  - o_m_rsp_ready=1.
  - i_m_rsp_valid: latch i_m_rsp_rdata for reads or 0 for writes, set error=0, go to RESPOND.
  - Timer expiry: rdata=0, error=1, go to RESPOND.
- RESPOND:
  - o_rsp_valid[g]=1; o_rsp_rdata/o_rsp_error held stable.
  - On i_rsp_ready[g]: pointer=g, go to IDLE.
- Pipelining: at most one transaction outstanding. Minimum request-accept to o_rsp_valid latency is 3 cycles, with a 0-wait master.
- Fairness: a channel continuously requesting waits at most NumChannels-1 transactions.
- Burst field is passed through unchanged; wdata bytes above burst count are forwarded unmodified.
- Simultaneous new valids during a busy transaction are ignored; o_req_ready stays 0.

Optional Feature:
I2C_ARB_TIMEOUT_EN:
- Defined: a 32-bit counter clears on WAIT_RSP entry and increments each cycle there. At count == TimeoutCycles-1 with no i_m_rsp_valid, a timeout completion is issued. A response in that same cycle wins: no error.
- Undefined: no counter; WAIT_RSP waits indefinitely; o_rsp_error tied 0.

Test Plan:
- Reset, then ch0 read slave 0x74 reg 0x00 burst 3; master returns 0x11223344 -> m_valid 1 cycle after accept; o_rsp_valid=0001, rdata 0x11223344, error 0.
- Channels 0-3 all valid continuously, 8 writes -> grant order 0,1,2,3,0,1,2,3.
- Master holds i_m_ready=0 for 10 cycles -> o_m_* fields stable; no other o_req_ready asserted.
- Timeout build, TimeoutCycles=16, no master response -> o_rsp_error=1, rdata 0, 16 cycles after WAIT_RSP entry; late response in IDLE dropped.
- i_rsp_ready low for 5 cycles in RESPOND -> o_rsp_valid/rdata held; then IDLE with pointer=g.
- i_rst pulsed during WAIT_RSP -> all outputs 0 next cycle; ch0 granted first afterwards.
